// File: rtl/core2axi4l_pipe.sv
// Pipelined core (req/gnt/rvalid) to AXI4-Lite master bridge, up to MAX_OUTSTANDING same-direction transactions.
// Optional macro CORE2AXI4L_PIPE_REG_RESP_EN registers the core response path (+1 cycle latency).
module core2axi4l_pipe #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [2:0]  PROT            = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  // core side
  input  logic                core_req,
  output logic                core_gnt,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic                core_we,
  input  logic [DATA_W/8-1:0] core_be,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_err,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [2:0]          axi_awprot,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [2:0]          axi_arprot,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready
);

  localparam int unsigned      CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       RESP_OKAY = 2'b00;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("core2axi4l_pipe: DATA_W must be 32 or 64");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_out
    $error("core2axi4l_pipe: MAX_OUTSTANDING must be in 1..15");
  end

  dir_e             dir_q, dir_d, req_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic             can_issue, aw_hs, w_hs, r_hs, b_hs, rd_gnt, wr_gnt;
  logic             resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;

  assign req_dir = core_we ? DIR_WRITE : DIR_READ;

  // Address/data are forwarded unregistered; the core holds them until gnt.
  assign axi_awaddr = core_addr;
  assign axi_araddr = core_addr;
  assign axi_wdata  = core_wdata;
  assign axi_wstrb  = core_be;
  assign axi_awprot = PROT;
  assign axi_arprot = PROT;

  // NOTE: every signal driven here gets a value on every path, otherwise synthesis infers latches.
  always_comb begin
    // Issue only against the registered count, so a response freeing a slot never allows a same-cycle grant.
    can_issue   = !rst && core_req && (cnt_q < CNT_MAX)
                  && ((cnt_q == '0) || (dir_q == req_dir));
    axi_arvalid = can_issue && !core_we;
    axi_awvalid = can_issue && core_we && !aw_done_q;
    axi_wvalid  = can_issue && core_we && !w_done_q;

    aw_hs  = axi_awvalid && axi_awready;
    w_hs   = axi_wvalid && axi_wready;
    rd_gnt = axi_arvalid && axi_arready;
    wr_gnt = can_issue && core_we && (aw_done_q || aw_hs) && (w_done_q || w_hs);
    core_gnt = rd_gnt || wr_gnt;

    axi_rready = !rst && (cnt_q != '0) && (dir_q == DIR_READ);
    axi_bready = !rst && (cnt_q != '0) && (dir_q == DIR_WRITE);
    r_hs = axi_rvalid && axi_rready;
    b_hs = axi_bvalid && axi_bready;

    resp_valid = r_hs || b_hs;
    resp_rdata = r_hs ? axi_rdata : '0;
    resp_err   = (r_hs && (axi_rresp != RESP_OKAY)) || (b_hs && (axi_bresp != RESP_OKAY));

    cnt_d = cnt_q;
    if (core_gnt && !resp_valid) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!core_gnt && resp_valid) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    dir_d     = core_gnt ? req_dir : dir_q;
    aw_done_d = core_gnt ? 1'b0 : (aw_done_q || aw_hs);
    w_done_d  = core_gnt ? 1'b0 : (w_done_q || w_hs);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dir_q     <= DIR_READ;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef CORE2AXI4L_PIPE_REG_RESP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
    end else begin
      core_rvalid <= resp_valid;
      core_err    <= resp_err;
    end
  end

  // NOTE: read data is qualified by core_rvalid, so this register needs no reset.
  always_ff @(posedge clk) begin
    core_rdata <= resp_rdata;
  end
`else
  assign core_rvalid = resp_valid;
  assign core_rdata  = resp_rdata;
  assign core_err    = resp_err;
`endif

endmodule

// File: tb/tb_core2axi4l_pipe.sv
// Self-checking bench for core2axi4l_pipe: cycle-by-cycle vector table plus reset and latency sequences.
// Honours CORE2AXI4L_PIPE_REG_RESP_EN by expecting core responses one cycle later.
module tb_core2axi4l_pipe;

`ifdef CORE2AXI4L_PIPE_REG_RESP_EN
  localparam int RESP_LAT = 1;
`else
  localparam int RESP_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_gnt, core_we, core_rvalid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_be;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core2axi4l_pipe #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .PROT(3'b000)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_addr(core_addr), .core_we(core_we),
    .core_be(core_be), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  // in_f:  {rst, req, we, awready, wready, arready, rvalid, bvalid}
  // exp_f: {gnt, awvalid, wvalid, arvalid, rready, bready, core_rvalid, core_err}
  typedef struct {
    logic [7:0]  in_f;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    logic [7:0]  exp_f;
    logic [31:0] crdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] in_f, input logic [31:0] addr, input logic [31:0] rdata,
                     input logic [1:0] rresp, input logic [1:0] bresp,
                     input logic [7:0] exp_f, input logic [31:0] crdata);
    vec_t v;
    v.in_f = in_f; v.addr = addr; v.rdata = rdata; v.rresp = rresp; v.bresp = bresp;
    v.exp_f = exp_f; v.crdata = crdata;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    rst         = v.in_f[7];
    core_req    = v.in_f[6];
    core_we     = v.in_f[5];
    axi_awready = v.in_f[4];
    axi_wready  = v.in_f[3];
    axi_arready = v.in_f[2];
    axi_rvalid  = v.in_f[1];
    axi_bvalid  = v.in_f[0];
    core_addr   = v.addr;
    core_wdata  = v.addr ^ 32'hA5A5_5A5A;
    core_be     = v.addr[5:2];
    axi_rdata   = v.rdata;
    axi_rresp   = v.rresp;
    axi_bresp   = v.bresp;
  endtask

  task automatic build_table();
    add(8'b0000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);           // idle out of reset
    // single read
    add(8'b0100_0100, 32'h1000, 32'h0, 2'd0, 2'd0, 8'b1001_0000, 32'h0);
    add(8'b0000_0010, 32'h0, 32'hDEADBEEF, 2'd0, 2'd0, 8'b0000_1010, 32'hDEADBEEF);
    add(8'b0000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);
    // write, awready late, SLVERR response
    add(8'b0110_1000, 32'h2000, 32'h0, 2'd0, 2'd0, 8'b0110_0000, 32'h0);
    add(8'b0110_1000, 32'h2000, 32'h0, 2'd0, 2'd0, 8'b0100_0000, 32'h0);
    add(8'b0110_1000, 32'h2000, 32'h0, 2'd0, 2'd0, 8'b0100_0000, 32'h0);
    add(8'b0111_1000, 32'h2000, 32'h0, 2'd0, 2'd0, 8'b1100_0000, 32'h0);
    add(8'b0000_0001, 32'h0, 32'h0, 2'd0, 2'd2, 8'b0000_0111, 32'h0);
    // four reads fill, fifth stalls, drains in order
    add(8'b0100_0100, 32'h3000, 32'h0, 2'd0, 2'd0, 8'b1001_0000, 32'h0);
    add(8'b0100_0100, 32'h3004, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0100, 32'h3008, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0100, 32'h300C, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0100, 32'h3010, 32'h0, 2'd0, 2'd0, 8'b0000_1000, 32'h0);
    add(8'b0100_0110, 32'h3010, 32'hA0, 2'd0, 2'd0, 8'b0000_1010, 32'hA0);
    add(8'b0100_0110, 32'h3010, 32'hB1, 2'd0, 2'd0, 8'b1001_1010, 32'hB1);
    add(8'b0000_0010, 32'h0, 32'hC2, 2'd0, 2'd0, 8'b0000_1010, 32'hC2);
    add(8'b0000_0010, 32'h0, 32'hD3, 2'd0, 2'd0, 8'b0000_1010, 32'hD3);
    add(8'b0000_0010, 32'h0, 32'hE4, 2'd0, 2'd0, 8'b0000_1010, 32'hE4);
    add(8'b0000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);
    // two reads outstanding, write waits for drain
    add(8'b0100_0100, 32'h4000, 32'h0, 2'd0, 2'd0, 8'b1001_0000, 32'h0);
    add(8'b0100_0100, 32'h4004, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0111_1100, 32'h5000, 32'h0, 2'd0, 2'd0, 8'b0000_1000, 32'h0);
    add(8'b0111_1110, 32'h5000, 32'h11, 2'd0, 2'd0, 8'b0000_1010, 32'h11);
    add(8'b0111_1110, 32'h5000, 32'h22, 2'd2, 2'd0, 8'b0000_1011, 32'h22);
    add(8'b0111_1100, 32'h5000, 32'h0, 2'd0, 2'd0, 8'b1110_0000, 32'h0);
    add(8'b0000_0001, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0110, 32'h0);
    // grant+response at cnt=2 keeps cnt, refill to 4, full-cycle response blocks grant, reset at cnt=3
    add(8'b0100_0100, 32'h6000, 32'h0, 2'd0, 2'd0, 8'b1001_0000, 32'h0);
    add(8'b0100_0100, 32'h6004, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0110, 32'h6008, 32'h33, 2'd0, 2'd0, 8'b1001_1010, 32'h33);
    add(8'b0100_0100, 32'h600C, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0100, 32'h6010, 32'h0, 2'd0, 2'd0, 8'b1001_1000, 32'h0);
    add(8'b0100_0100, 32'h6014, 32'h0, 2'd0, 2'd0, 8'b0000_1000, 32'h0);
    add(8'b0100_0110, 32'h6014, 32'h44, 2'd0, 2'd0, 8'b0000_1010, 32'h44);
    add(8'b1000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);
    add(8'b0000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);
    add(8'b0100_0100, 32'h7000, 32'h0, 2'd0, 2'd0, 8'b1001_0000, 32'h0);
    add(8'b0000_0010, 32'h0, 32'h55, 2'd0, 2'd0, 8'b0000_1010, 32'h55);
    add(8'b0000_0000, 32'h0, 32'h0, 2'd0, 2'd0, 8'b0000_0000, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        p_crv, p_err, e_crv, e_err, seen;
    logic [31:0] p_rdata, e_rdata;
    int          lat;
    vec_t        v;

    // reset with a request pending: nothing may be issued or granted
    rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_wdata = '0; core_be = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b1; axi_rvalid = 1'b0; axi_bvalid = 1'b0;
    axi_rdata = '0; axi_rresp = '0; axi_bresp = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst gnt", core_gnt, 1'b0);
    check("rst arvalid", axi_arvalid, 1'b0);
    check("rst rready", axi_rready, 1'b0);
    check("rst core_rvalid", core_rvalid, 1'b0);

    build_table();
    p_crv = 1'b0; p_err = 1'b0; p_rdata = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      apply(v);
      #2;
      e_crv   = (RESP_LAT != 0) ? p_crv   : v.exp_f[1];
      e_err   = (RESP_LAT != 0) ? p_err   : v.exp_f[0];
      e_rdata = (RESP_LAT != 0) ? p_rdata : v.crdata;
      check($sformatf("v%0d gnt", i), core_gnt, v.exp_f[7]);
      check($sformatf("v%0d awvalid", i), axi_awvalid, v.exp_f[6]);
      check($sformatf("v%0d wvalid", i), axi_wvalid, v.exp_f[5]);
      check($sformatf("v%0d arvalid", i), axi_arvalid, v.exp_f[4]);
      check($sformatf("v%0d rready", i), axi_rready, v.exp_f[3]);
      check($sformatf("v%0d bready", i), axi_bready, v.exp_f[2]);
      check($sformatf("v%0d core_rvalid", i), core_rvalid, e_crv);
      check($sformatf("v%0d core_err", i), core_err, e_err);
      if (e_crv) check($sformatf("v%0d core_rdata", i), core_rdata, e_rdata);
      check($sformatf("v%0d araddr", i), axi_araddr, v.addr);
      check($sformatf("v%0d awaddr", i), axi_awaddr, v.addr);
      check($sformatf("v%0d wdata", i), axi_wdata, v.addr ^ 32'hA5A5_5A5A);
      check($sformatf("v%0d wstrb", i), axi_wstrb, v.addr[5:2]);
      check($sformatf("v%0d prot", i), {axi_awprot, axi_arprot}, 6'b000_000);
      p_crv   = v.in_f[7] ? 1'b0 : v.exp_f[1];
      p_err   = v.in_f[7] ? 1'b0 : v.exp_f[0];
      p_rdata = v.crdata;
    end

    // request-to-response latency of an unloaded single read
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000; axi_arready = 1'b1;
    #2;
    check("lat gnt", core_gnt, 1'b1);
    @(negedge clk);
    core_req = 1'b0; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'hDEADBEEF; axi_rresp = 2'b00;
    seen = 1'b0; lat = 0;
    for (int k = 1; k <= 4; k++) begin
      #2;
      if (!seen && core_rvalid) begin
        seen = 1'b1;
        lat  = k;
        check("lat rdata", core_rdata, 32'hDEADBEEF);
        check("lat err", core_err, 1'b0);
      end
      @(negedge clk);
      axi_rvalid = 1'b0;
    end
    check("lat seen", seen, 1'b1);
    check("lat cycles", lat, 1 + RESP_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
